bit_shift_sched: RTL and testbench

BIT_SHIFT_SCHED -- requirements
Module: bit_shift_sched

---
 rtl/bit_shift_pkg.sv | 54 +++++
 rtl/rr_arbiter_2.sv | 19 +
 rtl/bit_shift_sched.sv | 130 +++++++++++++
 tb/tb_bit_shift_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_shift_pkg.sv
// ---------------------------------------------------------------------------
// bit_shift_pkg
// Shared definitions for the bit_shift_sched block:
//   state_t     - FSM state encoding (IDLE, SHIFT, DONE)
//   AMT_LSB     - bit position of the shift-amount field inside a cfg word
//   DIR_BIT     - offset of the direction bit above the amount field
//   WRAP_BIT    - offset of the wrap bit above the amount field
//   shift_step  - one-bit shift/rotate step used by the iterative datapath
// ---------------------------------------------------------------------------
package bit_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // cfg = {wrap, dir, amount}. The amount field width is a module parameter,
  // so dir/wrap are expressed as offsets above the top of that field:
  // dir lives at cfg[SHIFT_WIDTH + DIR_BIT], wrap at cfg[SHIFT_WIDTH + WRAP_BIT].
  localparam int AMT_LSB  = 0;
  localparam int DIR_BIT  = 0;
  localparam int WRAP_BIT = 1;

  // Widest operand the step function can handle.
  localparam int MAX_DATA_WIDTH = 64;

  // Single-bit shift of the low 'width' bits of 'value'.
  // dir 1 = right, 0 = left; wrap 1 = rotate, 0 = zero-fill.
  // Bits at and above 'width' are always returned as zero, so callers can
  // zero-extend a narrower operand and truncate the result back.
  function automatic logic [MAX_DATA_WIDTH-1:0] shift_step(
    input logic [MAX_DATA_WIDTH-1:0] value,
    input int                        width,
    input logic                      dir,
    input logic                      wrap
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    logic [MAX_DATA_WIDTH-1:0] res;
    logic [5:0]                msb;
    msb  = 6'(width - 1);
    mask = (width >= MAX_DATA_WIDTH) ? '1
                                     : ((64'd1 << width) - 64'd1);
    if (dir) begin
      res = (value & mask) >> 1;
      if (wrap) res[msb] = value[0];
    end else begin
      res = value << 1;
      if (wrap) res[0] = value[msb];
    end
    return res & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-requester arbiter with an external priority pointer. A lone valid
// requester always wins; when both are valid the pointer decides.
// Ports:
//   valid [1:0] - request lines (bit N = requester N)
//   ptr         - priority pointer, 0 = requester 0 preferred, 1 = requester 1
//   grant [1:0] - one-hot grant, all-zero when nothing is valid
// ---------------------------------------------------------------------------
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | ~ptr);
  assign grant[1] = valid[1] & (~valid[0] |  ptr);

endmodule

// File: rtl/bit_shift_sched.sv
// ---------------------------------------------------------------------------
// bit_shift_sched
// Serves two requesters with a shared iterative shifter. One job is accepted
// in IDLE (round-robin between requesters), shifted one bit per cycle in
// SHIFT, and presented in DONE until the consumer takes it.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   reqN_valid/ready         - request handshake, ready is combinational in IDLE
//   reqN_data [DATA_WIDTH]   - operand
//   reqN_cfg [SHIFT_WIDTH+2] - {wrap, dir, amount}
//   out_valid/out_ready      - result handshake
//   out_data [DATA_WIDTH]    - working register (meaningful while out_valid)
//   out_id                   - requester that owns the result
//   busy                     - high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module bit_shift_sched
  import bit_shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  output logic                   req0_ready,
  output logic                   req1_ready,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  input  logic [SHIFT_WIDTH+1:0] req0_cfg,
  input  logic [SHIFT_WIDTH+1:0] req1_cfg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_id,
  output logic                   busy
);

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   work_q;
  logic [SHIFT_WIDTH-1:0]  cnt_q;
  logic                    dir_q;
  logic                    wrap_q;
  logic                    id_q;
  logic                    ptr_q;

  logic [1:0]              arb_valid;
  logic [1:0]              grant;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [SHIFT_WIDTH+1:0]  sel_cfg;
  logic [SHIFT_WIDTH-1:0]  sel_amt;
  logic                    handshake;

  // Requests are only visible to the arbiter in IDLE, which keeps both
  // ready lines low and makes input changes irrelevant during a job.
  assign arb_valid = (state_q == IDLE) ? {req1_valid, req0_valid} : 2'b00;

  rr_arbiter_2 u_arb (
    .valid (arb_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign sel_data   = grant[1] ? req1_data : req0_data;
  assign sel_cfg    = grant[1] ? req1_cfg  : req0_cfg;
  assign sel_amt    = sel_cfg[AMT_LSB +: SHIFT_WIDTH];
  assign handshake  = (state_q == DONE) && out_ready;

  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_data   = work_q;
  assign out_id     = id_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A zero amount skips SHIFT entirely; otherwise SHIFT runs until the
  // counter reaches 1, giving exactly 'amount' shift cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (sel_amt == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == SHIFT_WIDTH'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job registers and the priority pointer. Reset is checked first so an
  // abort also wins over a handshake landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
      id_q   <= 1'b0;
      ptr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            work_q <= sel_data;
            cnt_q  <= sel_amt;
            dir_q  <= sel_cfg[SHIFT_WIDTH + DIR_BIT];
            wrap_q <= sel_cfg[SHIFT_WIDTH + WRAP_BIT];
            id_q   <= grant[1];
          end
        end
        SHIFT: begin
          work_q <= DATA_WIDTH'(shift_step(MAX_DATA_WIDTH'(work_q), DATA_WIDTH,
                                           dir_q, wrap_q));
          cnt_q  <= cnt_q - SHIFT_WIDTH'(1);
        end
        DONE: begin
          if (handshake) ptr_q <= ~ptr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_shift_sched.sv
// ---------------------------------------------------------------------------
// tb_bit_shift_sched
// Directed bench for bit_shift_sched (DATA_WIDTH=8, SHIFT_WIDTH=3) with
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_bit_shift_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [4:0] req0_cfg, req1_cfg;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_id;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bit_shift_sched #(.DATA_WIDTH(8), .SHIFT_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .req0_cfg   (req0_cfg),
    .req1_cfg   (req1_cfg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Run one job from a single requester: check the grant, the latency after
  // acceptance, the result, optional stall cycles in DONE, then the return
  // to IDLE after the handshake.
  task automatic applyStimulus(input logic id, input logic [7:0] data,
                               input logic [4:0] cfg, input logic [7:0] exp_data,
                               input int exp_lat, input int hold,
                               input string name);
    int n;
    if (id) begin
      req1_valid = 1'b1; req1_data = data; req1_cfg = cfg;
    end else begin
      req0_valid = 1'b1; req0_data = data; req0_cfg = cfg;
    end
    #1;
    checkOutput({name, "_grant"}, {30'd0, req1_ready, req0_ready},
                id ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput({name, "_latency"}, n, exp_lat);
    checkOutput({name, "_data"}, {24'd0, out_data}, {24'd0, exp_data});
    checkOutput({name, "_id"}, {31'd0, out_id}, {31'd0, id});
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req0_data = ~data;        req0_cfg = 5'b00001;
      req1_valid = 1'b1; req1_data = data ^ 8'h0F; req1_cfg = 5'b01010;
      #1;
      checkOutput({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({name, "_hold_data"}, {24'd0, out_data}, {24'd0, exp_data});
      checkOutput({name, "_hold_id"}, {31'd0, out_id}, {31'd0, id});
      checkOutput({name, "_hold_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready  = 1'b0;
    checkOutput({name, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({name, "_post_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] rr_data [2];
    rr_data[0] = 8'h02;
    rr_data[1] = 8'h40;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data  = 8'h00; req1_data = 8'h00;
    req0_cfg   = 5'b0; req1_cfg   = 5'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("rst_data",  {24'd0, out_data}, 32'd0);
    checkOutput("rst_id",    {31'd0, out_id}, 32'd0);
    rst = 1'b0;

    // cfg = {wrap, dir, amount}; dir 1 = right.
    applyStimulus(1'b0, 8'hB4, 5'b01011, 8'h16, 3, 0, "r0_shr3_zf");
    applyStimulus(1'b1, 8'hB4, 5'b10011, 8'hA5, 3, 0, "r1_rol3");
    applyStimulus(1'b0, 8'h5A, 5'b00000, 8'h5A, 0, 0, "amt0");
    applyStimulus(1'b1, 8'hFF, 5'b01111, 8'h01, 7, 0, "shr7_zf");
    applyStimulus(1'b0, 8'h81, 5'b11001, 8'hC0, 1, 0, "ror1");
    applyStimulus(1'b0, 8'hC3, 5'b00010, 8'h0C, 2, 0, "shl2_zf");
    applyStimulus(1'b1, 8'h3C, 5'b10010, 8'hF0, 2, 5, "stall5");

    // Both requesters pending: alternation starting from req0 after reset.
    doReset();
    req0_valid = 1'b1; req0_data = 8'h01; req0_cfg = 5'b00001;
    req1_valid = 1'b1; req1_data = 8'h80; req1_cfg = 5'b01001;
    out_ready  = 1'b1;
    #1;
    checkOutput("rr_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      checkOutput($sformatf("rr_wait_%0d", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("rr_id_%0d", k), {31'd0, out_id}, k % 2);
      checkOutput($sformatf("rr_data_%0d", k), {24'd0, out_data},
                  {24'd0, rr_data[k % 2]});
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    tick();

    // Reset in the middle of a long shift aborts the job silently.
    doReset();
    req0_valid = 1'b1; req0_data = 8'hFF; req0_cfg = 5'b00111;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy",  {31'd0, busy}, 32'd0);
    checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_data",  {24'd0, out_data}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checkOutput("abort_no_result", seen, 32'd0);

    // Reset and handshake together: reset wins, pointer stays on req0.
    req0_valid = 1'b1; req0_data = 8'h11; req0_cfg = 5'b00000;
    tick();
    req0_valid = 1'b0;
    checkOutput("prec_in_done", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    checkOutput("prec_valid", {31'd0, out_valid}, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("prec_ptr_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
